// File: rtl/i2c_target_regfile_if.sv
// I2C bus pins seen by the register-file target.
// master: drives SCL/SDA levels, observes the target's open-drain SDA drive.
// slave : samples SCL/SDA levels, drives its open-drain SDA enable.
interface i2c_target_regfile_if;
   logic scl_i;
   logic sda_i;
   logic sda_o;

   modport master (output scl_i, output sda_i, input sda_o);
   modport slave  (input scl_i, input sda_i, output sda_o);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target serving a byte register file: START/Sr/STOP decode, 7-bit address
// match, register pointer with auto-increment on writes and reads, local read port
// and committed-write strobe. All decode runs on the oversampling clock scl_4x.
// Optional feature macro: I2C_TGT_GENERAL_CALL_EN (ACK general call 8'h00 as a write).
module i2c_target_regfile #(
   parameter logic [6:0]  DEV_ADDR    = 7'h08,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                scl_4x,
   input  logic                rst_n,
   i2c_target_regfile_if.slave bus,
   input  logic [PTR_W-1:0]    loc_addr,
   output logic [7:0]          loc_rdata,
   output logic                wr_valid,
   output logic [PTR_W-1:0]    wr_addr,
   output logic [7:0]          wr_data,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_REG, S_WR, S_RD, S_IGNORE
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_dly_q, sda_dly_q;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic                   sampled_q, sampled_d;
   logic [7:0]             shift_q, shift_d;
   logic                   mack_q, mack_d;
   logic [7:0]             tx_q, tx_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   sda_q, sda_d;
   logic                   busy_q, busy_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [PTR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   reg_we_c;
   logic [7:0]             regs_q [NUM_REGS];

   logic scl_s, sda_s;
   logic scl_rise_c, scl_fall_c, start_c, stop_c;
   logic fall_ev_c, byte_end_c, ack_end_c;
   logic addr_ack_c, reg_ok_c;
   logic [PTR_W-1:0] ptr_inc_c;
   logic [7:0] rd_cur_c, rd_next_c;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Bus events on synchronized levels against their one-cycle-delayed copies
   assign scl_rise_c = scl_s & ~scl_dly_q;
   assign scl_fall_c = ~scl_s & scl_dly_q;
   assign start_c    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_c     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

   // The falling edge after START has no sampled bit behind it and is skipped
   assign fall_ev_c  = scl_fall_c & sampled_q;
   assign byte_end_c = fall_ev_c & (bit_cnt_q == 4'd7);
   assign ack_end_c  = fall_ev_c & (bit_cnt_q == 4'd8);

`ifdef I2C_TGT_GENERAL_CALL_EN
   assign addr_ack_c = (shift_q[7:1] == DEV_ADDR) || (shift_q == 8'h00);
`else
   assign addr_ack_c = (shift_q[7:1] == DEV_ADDR);
`endif

   assign reg_ok_c  = ({1'b0, shift_q} < 9'(NUM_REGS));
   assign ptr_inc_c = ptr_q + PTR_W'(1);
   assign rd_cur_c  = regs_q[ptr_q];
   assign rd_next_c = regs_q[ptr_inc_c];

   assign bus.sda_o = sda_q;
   assign busy      = busy_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign loc_rdata = regs_q[loc_addr];

   // Input synchronizers and edge-detect history (idle bus level is high)
   always_ff @(posedge scl_4x or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_sync_q <= SYNC_STAGES'({scl_sync_q, bus.scl_i});
         sda_sync_q <= SYNC_STAGES'({sda_sync_q, bus.sda_i});
         scl_dly_q  <= scl_s;
         sda_dly_q  <= sda_s;
      end
   end

   // State register and bit-level sequencing registers
   always_ff @(posedge scl_4x or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 4'd0;
         sampled_q <= 1'b0;
         shift_q   <= 8'h00;
         mack_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sampled_q <= sampled_d;
         shift_q   <= shift_d;
         mack_q    <= mack_d;
      end
   end

   // Next state: bit counting, shifting and protocol transitions
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sampled_d = sampled_q;
      shift_d   = shift_q;
      mack_d    = mack_q;

      if (scl_rise_c) begin
         sampled_d = 1'b1;
         if (bit_cnt_q < 4'd8) shift_d = {shift_q[6:0], sda_s};
         else                  mack_d  = sda_s;
      end
      if (fall_ev_c) begin
         sampled_d = 1'b0;
         bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
      end

      case (state_q)
         S_ADDR: begin
            if (byte_end_c && !addr_ack_c) state_d = S_IGNORE;
            else if (ack_end_c)            state_d = shift_q[0] ? S_RD : S_REG;
         end
         S_REG: begin
            if (byte_end_c && !reg_ok_c) state_d = S_IGNORE;
            else if (ack_end_c)          state_d = S_WR;
         end
         S_RD: begin
            if (ack_end_c && mack_q) state_d = S_IGNORE;
         end
         default: ;
      endcase

      if (stop_c) begin
         state_d   = S_IDLE;
         bit_cnt_d = 4'd0;
         sampled_d = 1'b0;
      end else if (start_c) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         sampled_d = 1'b0;
      end
   end

   // Outputs: SDA drive, busy, pointer, write strobe and read shifter
   always_comb begin
      sda_d      = sda_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      ptr_d      = ptr_q;
      tx_d       = tx_q;
      reg_we_c   = 1'b0;

      case (state_q)
         S_ADDR: begin
            if (byte_end_c) begin
               sda_d  = ~addr_ack_c;
               busy_d = addr_ack_c;
            end else if (ack_end_c) begin
               if (shift_q[0]) begin
                  sda_d = rd_cur_c[7];
                  tx_d  = {rd_cur_c[6:0], 1'b0};
               end else begin
                  sda_d = 1'b1;
               end
            end
         end
         S_REG: begin
            if (byte_end_c) begin
               sda_d = ~reg_ok_c;
               if (reg_ok_c) ptr_d = PTR_W'(shift_q);
            end else if (ack_end_c) begin
               sda_d = 1'b1;
            end
         end
         S_WR: begin
            if (byte_end_c) begin
               reg_we_c   = 1'b1;
               wr_valid_d = 1'b1;
               wr_addr_d  = ptr_q;
               wr_data_d  = shift_q;
               ptr_d      = ptr_inc_c;
               sda_d      = 1'b0;
            end else if (ack_end_c) begin
               sda_d = 1'b1;
            end
         end
         S_RD: begin
            if (fall_ev_c) begin
               if (bit_cnt_q == 4'd8) begin
                  ptr_d = ptr_inc_c;
                  if (!mack_q) begin
                     sda_d = rd_next_c[7];
                     tx_d  = {rd_next_c[6:0], 1'b0};
                  end else begin
                     sda_d = 1'b1;
                  end
               end else if (bit_cnt_q == 4'd7) begin
                  sda_d = 1'b1;
               end else begin
                  sda_d = tx_q[7];
                  tx_d  = {tx_q[6:0], 1'b0};
               end
            end
         end
         default: sda_d = 1'b1;
      endcase

      if (stop_c) begin
         sda_d  = 1'b1;
         busy_d = 1'b0;
      end else if (start_c) begin
         sda_d = 1'b1;
      end
   end

   // Registered outputs and datapath; reset releases SDA immediately
   always_ff @(posedge scl_4x or negedge rst_n) begin
      if (!rst_n) begin
         sda_q      <= 1'b1;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
         ptr_q      <= '0;
         tx_q       <= 8'h00;
      end else begin
         sda_q      <= sda_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ptr_q      <= ptr_d;
         tx_q       <= tx_d;
      end
   end

   // Register file, written only from the bus
   always_ff @(posedge scl_4x or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: 8'h00};
      end else if (reg_we_c) begin
         regs_q[ptr_q] <= shift_q;
      end
   end

endmodule
